// File: rtl/muldiv_exec_unit_pkg.sv
// Shared RV32M mul/div types and the latency constants the stall resolver counts against.
// MUL_COUNT/DIV_COUNT are the single source of truth for execute latency.
package muldiv_exec_unit_pkg;

    localparam int MUL_COUNT = 4;
    localparam int DIV_COUNT = 36;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_DIV_FIX,
        S_PAD,
        S_DONE
    } muldiv_state_t;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_exec_unit_div_core.sv
// Unsigned radix-2 restoring divider: XLEN iterations after start, one per clock.
// last_iter is high during the cycle whose edge completes the final iteration.
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last_iter
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   iter_cnt;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, dvs_q};
    end

    // A divisor of zero falls out as quotient all-ones, remainder = dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
        end else if (abort) begin
            iter_cnt <= '0;
        end else if (start) begin
            quo_q    <= dividend;
            rem_q    <= '0;
            dvs_q    <= divisor;
            iter_cnt <= CW'(XLEN);
        end else if (iter_cnt != '0) begin
            if (trial[XLEN]) begin
                rem_q <= rem_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_q <= trial[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end
            iter_cnt <= iter_cnt - CW'(1);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last_iter = (iter_cnt == CW'(1));

endmodule

// File: rtl/muldiv_exec_unit.sv
// RV32M execute unit: registered multiplier plus iterative divider, padded to a fixed latency
// so done lines up exactly with the stall resolver's MUL_COUNT/DIV_COUNT countdown.
module muldiv_exec_unit
    import muldiv_exec_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = MUL_COUNT,
    parameter int DIV_LAT = DIV_COUNT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush_e,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW      = $clog2(LAT_MAX + 1);

    muldiv_state_t   state, state_nxt;
    logic [CW-1:0]   cnt_q;
    logic            accept;
    logic            cnt_one;

    logic            a_sgn, b_sgn;
    logic signed [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0] mul_sel;

    logic            div_signed, sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN-1:0] core_quo, core_rem;
    logic            core_last;

    logic            qneg_q, rneg_q, dbz_q, is_rem_q;
    logic [XLEN-1:0] q_fix, r_fix, div_fixed;
    logic [XLEN-1:0] pend_q, result_q, res_nxt;
    logic            load_result;

    assign accept  = op_valid && (state == S_IDLE) && !flush_e;
    assign cnt_one = (cnt_q == CW'(1));

    // Sign/zero-extension to 33 bits is the real operand width; computing in 64 bits keeps every product bit used.
    always_comb begin
        a_sgn   = (funct3 != MD_MULHU);
        b_sgn   = (funct3 == MD_MUL) || (funct3 == MD_MULH);
        a_ext   = {{XLEN{a_sgn & src_a[XLEN-1]}}, src_a};
        b_ext   = {{XLEN{b_sgn & src_b[XLEN-1]}}, src_b};
        prod    = a_ext * b_ext;
        mul_sel = (funct3 == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        div_signed = (funct3 == MD_DIV) || (funct3 == MD_REM);
        sa         = div_signed & src_a[XLEN-1];
        sb         = div_signed & src_b[XLEN-1];
        abs_a      = sa ? (~src_a + XLEN'(1)) : src_a;
        abs_b      = sb ? (~src_b + XLEN'(1)) : src_b;
    end

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div_op(funct3)),
        .abort     (flush_e),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (core_quo),
        .remainder (core_rem),
        .last_iter (core_last)
    );

    // Overflow (MIN / -1) needs no special case: |MIN|/1 = MIN and the quotient sign is positive.
    always_comb begin
        q_fix     = dbz_q ? '1 : (qneg_q ? (~core_quo + XLEN'(1)) : core_quo);
        r_fix     = rneg_q ? (~core_rem + XLEN'(1)) : core_rem;
        div_fixed = is_rem_q ? r_fix : q_fix;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_div_op(funct3))  state_nxt = S_DIV_RUN;
                    else if (MUL_LAT == 1)  state_nxt = S_DONE;
                    else                    state_nxt = S_MUL_WAIT;
                end
            end
            S_MUL_WAIT: if (cnt_one)   state_nxt = S_DONE;
            S_DIV_RUN:  if (core_last) state_nxt = S_DIV_FIX;
            S_DIV_FIX:  state_nxt = cnt_one ? S_DONE : S_PAD;
            S_PAD:      if (cnt_one)   state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (flush_e) state_nxt = S_IDLE;
    end

    always_comb begin
        res_nxt = pend_q;
        if (state == S_IDLE)         res_nxt = mul_sel;
        else if (state == S_DIV_FIX) res_nxt = div_fixed;
        load_result = (state_nxt == S_DONE) && (state != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            is_rem_q <= 1'b0;
            pend_q   <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt_q    <= is_div_op(funct3) ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
                qneg_q   <= sa ^ sb;
                rneg_q   <= sa;
                dbz_q    <= (src_b == '0);
                is_rem_q <= funct3[1];
                pend_q   <= mul_sel;
            end else if (flush_e) begin
                cnt_q <= '0;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (state == S_DIV_FIX) pend_q <= div_fixed;
            if (load_result)        result_q <= res_nxt;
        end
    end

    assign busy   = (state != S_IDLE) && (state != S_DONE);
    assign done   = (state == S_DONE);
    assign result = result_q;

    a_no_op_while_busy: assert property (@(posedge clk) disable iff (rst) !(op_valid && busy))
        else $warning("muldiv_exec_unit: op_valid while busy, op ignored");

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Self-checking bench for muldiv_exec_unit: spec vectors, random ops against an arithmetic model,
// and hand-written flush / back-to-back / ignored-op / async-reset sequences.
module tb_muldiv_exec_unit;
    import muldiv_exec_unit_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = MUL_COUNT;
    localparam int DIV_LAT = DIV_COUNT;

    logic            clk, rst, op_valid, flush_e;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a, src_b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_exec_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .funct3(funct3),
        .src_a(src_a), .src_b(src_b), .flush_e(flush_e),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int ia, ib;
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3);
        return f3[2] ? DIV_LAT : MUL_LAT;
    endfunction

    // Starts in cycle 1 (first negedge after accept); returns the cycle in which done was seen, -1 on timeout.
    task automatic wait_done(output logic [31:0] res, output int lat);
        lat = -1;
        res = 'x;
        for (int c = 1; c <= DIV_LAT + 8; c++) begin
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        op_valid = 1'b1; funct3 = f3; src_a = a; src_b = b;
        @(negedge clk);
        op_valid = 1'b0;
        wait_done(res, lat);
    endtask

    task automatic run_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int lat;
        do_op(f3, a, b, res, lat);
        check({name, "_lat"}, lat, exp_lat(f3));
        check({name, "_res"}, res, exp);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, a, b, last_exp;
        logic [2:0]  f3;
        int lat, cnt;
        bit seen;

        rst = 1'b1; op_valid = 1'b0; flush_e = 1'b0; funct3 = 3'd0; src_a = '0; src_b = '0;

        vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14});
        vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd6, 32'd5,         32'd0,         32'd5});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9});

        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            run_check($sformatf("rnd%0d_f%0d_%h_%h", i, f3, a, b), f3, a, b, model(f3, a, b));
        end

        // op_valid held through the DONE cycle: accepted only in the following IDLE cycle.
        do_op(3'd0, 32'd2, 32'd21, res, lat);
        check("b2b_first", res, 32'd42);
        op_valid = 1'b1; funct3 = 3'd0; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        check("b2b_not_accepted_in_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        wait_done(res, lat);
        check("b2b_lat", lat, MUL_LAT);
        check("b2b_res", res, 32'd9);
        last_exp = 32'd9;

        // Flush in cycle 10 of a DIV: no done, idle next cycle, result untouched.
        @(negedge clk);
        op_valid = 1'b1; funct3 = 3'd4; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
        @(negedge clk);
        op_valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            seen |= done;
            @(negedge clk);
        end
        flush_e = 1'b1;
        @(negedge clk);
        flush_e = 1'b0;
        check("flush_busy_next", {31'b0, busy}, 32'd0);
        for (int c = 0; c < DIV_LAT + 4; c++) begin
            seen |= done;
            @(negedge clk);
        end
        check("flush_no_done", {31'b0, seen}, 32'd0);
        check("flush_result_kept", result, last_exp);
        run_check("post_flush_mul", 3'd0, 32'd3, 32'd3, 32'd9);

        // op_valid during busy is ignored: only the first op completes.
        @(negedge clk);
        op_valid = 1'b1; funct3 = 3'd0; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; funct3 = 3'd5; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        cnt = 0;
        lat = -1;
        for (int c = 3; c <= MUL_LAT + DIV_LAT + 4; c++) begin
            if (done && lat < 0) begin
                lat = c;
                res = result;
            end
            if (busy && lat >= 0) cnt++;
            @(negedge clk);
        end
        check("ignore_lat", lat, MUL_LAT);
        check("ignore_res", res, 32'd30);
        check("ignore_no_second_op", cnt, 32'd0);

        // Asynchronous reset pulse mid-DIV, away from any clock edge.
        @(negedge clk);
        op_valid = 1'b1; funct3 = 3'd5; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < DIV_LAT + 4; c++) begin
            @(negedge clk);
            seen |= done;
        end
        check("rst_no_done", {31'b0, seen}, 32'd0);
        run_check("post_rst_mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
